// File: rtl/shot_pkg.sv
// Shared types and widths for the pool-game shot sequencer.
// Holds the FSM state encoding and the fixed aim/power widths.
package shot_pkg;

    localparam int DIR_BITS   = 4;
    localparam int POWER_BITS = 4;
    localparam int VEC_SCALE  = 7;

    typedef enum logic [2:0] {
        ST_AIM      = 3'd0,
        ST_CHARGE   = 3'd1,
        ST_FIRE     = 3'd2,
        ST_ROLLING  = 3'd3,
        ST_GAMEOVER = 3'd4
    } shot_state_t;

endpackage

// File: rtl/aim_vector_lut.sv
// 16-direction unit-vector ROM, scaled by VEC_SCALE and rounded.
// Direction 0 points along +x and direction 4 along +y (screen down).
module aim_vector_lut
    import shot_pkg::*;
(
    input  logic [DIR_BITS-1:0] dir,
    output logic signed [3:0]   cos_v,
    output logic signed [3:0]   sin_v
);

    localparam logic signed [3:0] FULL = 4'(VEC_SCALE);

    function automatic logic signed [3:0] cos_entry(input logic [3:0] k);
        case (k)
            4'd0:    return FULL;
            4'd1:    return 4'sd6;
            4'd2:    return 4'sd5;
            4'd3:    return 4'sd3;
            4'd4:    return 4'sd0;
            4'd5:    return -4'sd3;
            4'd6:    return -4'sd5;
            4'd7:    return -4'sd6;
            4'd8:    return -FULL;
            4'd9:    return -4'sd6;
            4'd10:   return -4'sd5;
            4'd11:   return -4'sd3;
            4'd12:   return 4'sd0;
            4'd13:   return 4'sd3;
            4'd14:   return 4'sd5;
            default: return 4'sd6;
        endcase
    endfunction

    // sin(k) is cos(k - 90 deg), i.e. the same table shifted by a quarter turn.
    assign cos_v = cos_entry(dir);
    assign sin_v = cos_entry(dir - 4'd4);

endmodule

// File: rtl/shot_controller.sv
// Per-turn shot sequencer: aim, charge, fire, then wait for the table to settle.
// Key and stop inputs act on frame ticks; turn_over and game_over act every cycle.
module shot_controller
    import shot_pkg::*;
#(
    parameter int POWER_MAX           = 15,
    parameter int POWER_STEP_FRAMES   = 4,
    parameter int STOP_TIMEOUT_FRAMES = 600,
    parameter int DIR_COUNT           = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  startOfFrame,
    input  logic                  key_left,
    input  logic                  key_right,
    input  logic                  key_shoot,
    input  logic                  turn_over,
    input  logic                  game_over,
    output logic [DIR_BITS-1:0]   aim_dir,
    output logic [POWER_BITS-1:0] power,
    output logic                  shot_valid,
    output logic signed [7:0]     shot_dx,
    output logic signed [7:0]     shot_dy,
    output logic                  white_started,
    output logic                  force_stop,
    output logic [2:0]            state_out
);

    localparam int CNT_BITS = $clog2(STOP_TIMEOUT_FRAMES + 1);
    localparam logic [CNT_BITS-1:0]   STEP_LAST    = CNT_BITS'(POWER_STEP_FRAMES - 1);
    localparam logic [CNT_BITS-1:0]   TIMEOUT_LAST = CNT_BITS'(STOP_TIMEOUT_FRAMES - 1);
    localparam logic [POWER_BITS-1:0] POWER_TOP    = POWER_BITS'(POWER_MAX);

    shot_state_t           state, state_d;
    logic [DIR_BITS-1:0]   aim_d;
    logic [POWER_BITS-1:0] power_d;
    logic [CNT_BITS-1:0]   cnt, cnt_d;
    logic                  prev_left, prev_right, prev_shoot;
    logic                  shot_valid_d, white_d, force_d;
    logic signed [7:0]     dx_d, dy_d;
    logic                  left_edge, right_edge, shoot_edge;
    logic signed [3:0]     cos_v, sin_v;
    logic signed [7:0]     cos_ext, sin_ext, power_ext;

    aim_vector_lut u_lut (
        .dir   (aim_dir),
        .cos_v (cos_v),
        .sin_v (sin_v)
    );

    assign left_edge  = startOfFrame & key_left  & ~prev_left;
    assign right_edge = startOfFrame & key_right & ~prev_right;
    assign shoot_edge = startOfFrame & key_shoot & ~prev_shoot;

    // |cos|*power <= 7*15 = 105, so an 8-bit signed product cannot overflow.
    assign cos_ext   = 8'(cos_v);
    assign sin_ext   = 8'(sin_v);
    assign power_ext = {{(8 - POWER_BITS){1'b0}}, power};

    assign state_out = state;

    always_comb begin
        // NOTE: every signal gets a default before the case, so no path leaves it unassigned (no latch).
        state_d      = state;
        aim_d        = aim_dir;
        power_d      = power;
        cnt_d        = cnt;
        shot_valid_d = 1'b0;
        force_d      = 1'b0;
        white_d      = white_started;
        dx_d         = shot_dx;
        dy_d         = shot_dy;

        if (game_over) begin
            state_d = ST_GAMEOVER;
            power_d = '0;
            white_d = 1'b0;
        end else begin
            case (state)
                ST_AIM: begin
                    if (shoot_edge) begin
                        state_d = ST_CHARGE;
                        power_d = POWER_BITS'(1);
                        cnt_d   = '0;
                    end else if (left_edge && !right_edge) begin
                        aim_d = aim_dir - 1'b1;
                    end else if (right_edge && !left_edge) begin
                        aim_d = aim_dir + 1'b1;
                    end
                end
                ST_CHARGE: begin
                    if (startOfFrame) begin
                        if (!key_shoot) begin
                            state_d = ST_FIRE;
                        end else if (cnt == STEP_LAST) begin
                            cnt_d = '0;
                            if (power != POWER_TOP) power_d = power + 1'b1;
                        end else begin
                            cnt_d = cnt + 1'b1;
                        end
                    end
                end
                ST_FIRE: begin
                    shot_valid_d = 1'b1;
                    dx_d         = cos_ext * power_ext;
                    dy_d         = sin_ext * power_ext;
                    white_d      = 1'b1;
                    cnt_d        = '0;
                    state_d      = ST_ROLLING;
                end
                ST_ROLLING: begin
                    // A settled table beats the timeout in the same cycle.
                    if (turn_over) begin
                        state_d = ST_AIM;
                        power_d = '0;
                        white_d = 1'b0;
                    end else if (startOfFrame) begin
                        if (cnt == TIMEOUT_LAST) begin
                            force_d = 1'b1;
                            power_d = '0;
                            white_d = 1'b0;
                            state_d = ST_AIM;
                        end else begin
                            cnt_d = cnt + 1'b1;
                        end
                    end
                end
                ST_GAMEOVER: begin
                    power_d = '0;
                    white_d = 1'b0;
                end
                default: state_d = ST_AIM;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_AIM;
            aim_dir       <= '0;
            power         <= '0;
            cnt           <= '0;
            prev_left     <= 1'b0;
            prev_right    <= 1'b0;
            prev_shoot    <= 1'b0;
            shot_valid    <= 1'b0;
            shot_dx       <= '0;
            shot_dy       <= '0;
            white_started <= 1'b0;
            force_stop    <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values, like real flops.
            state         <= state_d;
            aim_dir       <= aim_d;
            power         <= power_d;
            cnt           <= cnt_d;
            shot_valid    <= shot_valid_d;
            shot_dx       <= dx_d;
            shot_dy       <= dy_d;
            white_started <= white_d;
            force_stop    <= force_d;
            if (startOfFrame) begin
                prev_left  <= key_left;
                prev_right <= key_right;
                prev_shoot <= key_shoot;
            end
        end
    end

endmodule

// File: doc/shot_controller.md
Name: shot_controller

Overview:
- Per-turn shot sequencer for the VGA pool game. It takes player keys, sets aim direction and shot power, launches the white ball with a velocity vector, then waits for the table to settle before re-arming for the next turn.
- Sits between the keypad decoder and the white-ball motion block. It consumes turn_over and game-over status from the game controller.
- All key and stop inputs are sampled only on startOfFrame. This gives frame-rate UI behaviour.

Parameters:
- POWER_MAX, 15: saturation value of power, 4-bit.
- POWER_STEP_FRAMES, 4: frames per power increment while charging.
- STOP_TIMEOUT_FRAMES, 600: frames allowed in ROLLING before a forced stop.
- DIR_COUNT, 16: number of aim directions. Fixed at 16; the LUT depends on it.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- startOfFrame  in  1  one-cycle pulse per frame
- key_left  in  1  level, rotate aim counter-clockwise
- key_right  in  1  level, rotate aim clockwise
- key_shoot  in  1  level; hold to charge, release to fire
- turn_over  in  1  level from the game controller; the turn has ended
- game_over  in  1  level; the game has finished
- aim_dir  out  4  current direction index; 0=+x, 4=+y (screen down)
- power  out  4  current charge, 0..POWER_MAX
- shot_valid  out  1  one-cycle launch strobe
- shot_dx  out  8  signed x velocity, valid with shot_valid
- shot_dy  out  8  signed y velocity, valid with shot_valid
- white_started  out  1  high from launch until the turn ends
- force_stop  out  1  one-cycle pulse on timeout; the ball blocks zero their speed
- state_out  out  3  encoded FSM state, for debug and HUD

Behaviour:
- Reset values (asynchronous): state=AIM, aim_dir=0, power=0, shot_valid=0, shot_dx=0, shot_dy=0, white_started=0, force_stop=0, frame counter=0, sampled key registers=0.
- Key sampling: on startOfFrame, key_* are registered into prev_* registers. Edges are computed frame-to-frame. Between frames, key changes are ignored.
- State AIM:
  - Per frame, a key_left rising edge sets aim_dir-1 and a key_right rising edge sets aim_dir+1, both mod 16 (15+1 wraps to 0; 0-1 wraps to 15).
  - Both edges in the same frame: aim_dir holds.
  - A key_shoot rising edge sets power=1, clears the counter and moves to CHARGE. A shoot edge takes priority over a rotate edge in the same frame.
- State CHARGE:
  - aim_dir is frozen.
  - Counter increments each frame. When it reaches POWER_STEP_FRAMES-1, power increments (saturating at POWER_MAX) and the counter clears.
  - key_shoot sampled low moves to FIRE.
- State FIRE (exactly one clk cycle):
  - shot_valid=1.
  - shot_dx = cos_lut[aim_dir]*power and shot_dy = sin_lut[aim_dir]*power, as signed 4b × unsigned 4b into signed 8b. The range is ±105, so there is no overflow.
  - white_started is set to 1. The counter clears. Next state is ROLLING.
- State ROLLING:
  - Keys are ignored. Counter increments per frame.
  - turn_over high (sampled every cycle) moves to AIM. On that transition, power=0 and white_started=0; aim_dir is retained.
  - Counter reaching STOP_TIMEOUT_FRAMES: force_stop pulses 1 cycle, white_started=0, power=0, next state AIM.
  - turn_over and timeout in the same cycle: turn_over wins and force_stop is not pulsed.
- State GAMEOVER:
  - Entered from any state when game_over=1. This check has top priority, including in the FIRE cycle; in that case shot_valid is suppressed.
  - Outputs power=0, white_started=0.
  - Sticky until reset.
- shot_dx/shot_dy hold their last values after FIRE. Consumers use them only with shot_valid.
- Reset mid-shot returns to AIM immediately. No shot_valid is emitted.
- State encoding: AIM=0, CHARGE=1, FIRE=2, ROLLING=3, GAMEOVER=4.

Decomposition:
- Package shot_pkg holds:
  - the enum shot_state_t (3-bit, encoded as above);
  - the constants DIR_BITS=4 and POWER_BITS=4;
  - the LUT scale constant VEC_SCALE=7.
- Sub-module aim_vector_lut is a combinational 16-entry ROM. Input dir[3:0]; outputs cos_v and sin_v as signed 4-bit.
- LUT values are round(7·cos/sin(k·22.5°)):
  - cos = 7,6,5,3,0,-3,-5,-6,-7,-6,-5,-3,0,3,5,6
  - sin is the same table rotated by 4 (sin[k]=cos[(k-4) mod 16]).

Test Plan:
- Reset, then 3 frames with key_right edges → aim_dir=3. Then one key_left edge → aim_dir=2. From aim_dir=0, one key_left edge → 15.
- aim_dir=0, hold key_shoot 20 frames, release → power=5 (1 + ⌊19/4⌋ = 5; verify the exact count), FIRE: shot_valid for one cycle with shot_dx=35, shot_dy=0, and white_started=1.
- aim_dir=4, hold key_shoot 100 frames → power saturates at 15; release gives shot_dx=0, shot_dy=105.
- In ROLLING, assert turn_over at frame 50 → state AIM, power=0, white_started=0, force_stop never pulsed.
- In ROLLING, never assert turn_over → at frame 600 force_stop pulses one cycle and the state returns to AIM. A second variant asserts turn_over and timeout together → no force_stop.
- Assert game_over during CHARGE → state GAMEOVER with no shot_valid; keys have no effect; reset returns to AIM with aim_dir=0.
